// File: rtl/idct8x8_stream.sv
// Streaming 8x8 inverse DCT: load 64 coefficients, row pass and column pass
// on one shared MAC (8 clocks per element), then stream 64 clamped pixels.
module idct8x8_stream #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int MID_W = 20,
  parameter int ACC_W = 40
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             lshift_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  // The basis ROM is scaled by 2^13 and already carries c(k); the orthonormal
  // 8-point basis also has a factor 1/2, so each pass drops 14 bits, half-up.
  localparam int SHIFT = 14;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (SHIFT-1);
  localparam logic signed [ACC_W-1:0] MID_MAX = (ACC_W'(1) << (MID_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MID_MIN = -MID_MAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] LSH     = ACC_W'(1) << (OUT_W-1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = (ACC_W'(1) << OUT_W) - ACC_W'(1);

  typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_e;

  state_e            state_q;
  logic [8:0]        cnt_q;
  logic              lshift_q, in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [OUT_W-1:0]  out_data_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [IN_W-1:0]  coef_mem [64];
  logic signed [MID_W-1:0] mid_mem  [64];
  logic [OUT_W-1:0]        pix_mem  [64];

  // 2^13 * c(k) * cos((2x+1)k*pi/16), folded onto the first quadrant
  function automatic logic signed [15:0] kval(input logic [2:0] x, input logic [2:0] k);
    logic [6:0] ph;
    logic [4:0] m, n;
    logic       neg;
    logic signed [15:0] c;
    ph  = 7'({x, 1'b1}) * 7'(k);
    m   = ph[4:0];
    neg = 1'b0;
    if (m <= 5'd8)       n = m;
    else if (m <= 5'd16) begin n = 5'd16 - m; neg = 1'b1; end
    else if (m <= 5'd24) begin n = m - 5'd16; neg = 1'b1; end
    else                 n = 5'd0 - m;
    case (n)
      5'd0:    c = 16'sd8192;
      5'd1:    c = 16'sd8035;
      5'd2:    c = 16'sd7568;
      5'd3:    c = 16'sd6811;
      5'd4:    c = 16'sd5793;
      5'd5:    c = 16'sd4551;
      5'd6:    c = 16'sd3135;
      5'd7:    c = 16'sd1598;
      default: c = 16'sd0;
    endcase
    if (k == 3'd0) return 16'sd5793;
    return neg ? -c : c;
  endfunction

  // Counter fields: ea/eb pick the element, kk is the MAC tap
  logic [2:0] kk, ea, eb, kx;
  assign kk = cnt_q[2:0];
  assign eb = cnt_q[5:3];
  assign ea = cnt_q[8:6];
  assign kx = (state_q == ROW) ? eb : ea;

  logic signed [MID_W-1:0] a_s;
  logic signed [15:0]      k_s;
  logic signed [ACC_W-1:0] prod, sum, rnd, pr;
  logic signed [MID_W-1:0] mid_res;
  logic [OUT_W-1:0]        pix_res;
  logic [5:0]              nxt;

  assign nxt = cnt_q[5:0] + 6'd1;
  assign k_s = kval(kx, kk);

  // Shared MAC datapath: operand select, multiply-accumulate, round, saturate/clamp
  always_comb begin
    if (state_q == ROW) a_s = MID_W'(coef_mem[{ea, kk}]);
    else                a_s = mid_mem[{kk, eb}];
    prod = ACC_W'(a_s) * ACC_W'(k_s);
    if (kk == 3'd0) sum = prod;
    else            sum = acc_q + prod;
    rnd = (sum + RND) >>> SHIFT;
    if (rnd > MID_MAX)      mid_res = MID_MAX[MID_W-1:0];
    else if (rnd < MID_MIN) mid_res = MID_MIN[MID_W-1:0];
    else                    mid_res = rnd[MID_W-1:0];
    pr = lshift_q ? (rnd + LSH) : rnd;
    if (pr < 0)            pix_res = '0;
    else if (pr > PIX_MAX) pix_res = '1;
    else                   pix_res = pr[OUT_W-1:0];
  end

  // Block storage; contents are don't-care after reset
  always_ff @(posedge sys_clk) begin
    if (state_q == LOAD && in_valid && in_ready_q) coef_mem[cnt_q[5:0]] <= in_data;
    if (state_q == ROW && kk == 3'd7) mid_mem[{ea, eb}] <= mid_res;
    if (state_q == COL && kk == 3'd7) pix_mem[{ea, eb}] <= pix_res;
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      acc_q       <= '0;
      lshift_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (cnt_q[5:0] == 6'd0) lshift_q <= lshift_en;
            if (cnt_q[5:0] == 6'd63) begin
              state_q    <= ROW;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              cnt_q <= {3'd0, nxt};
            end
          end
        end
        ROW: begin
          acc_q <= sum;
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) state_q <= COL;
        end
        COL: begin
          acc_q <= sum;
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= pix_mem[0];
            out_last_q  <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (cnt_q[5:0] == 6'd63) begin
              state_q     <= LOAD;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              cnt_q      <= {3'd0, nxt};
              out_data_q <= pix_mem[nxt];
              out_last_q <= (nxt == 6'd63);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
